// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage data-memory access engine. Launches one SRAM-like bus
//   transaction per live load/store taken from the EX/MEM latch. It places
//   store data on the correct byte lanes and extends load data. Misaligned
//   accesses raise AdEL/AdES combinationally. mem_stall_o holds the pipeline
//   until the access completes.
//
//   Optional feature macro: MEM_UNALIGNED_LWLR_EN
//     defined   : LWL/LWR/SWL/SWR (memops 9..C) access the word-aligned
//                 address with merged/shifted data.
//     undefined : memops 9..C behave as "none".
//
//   Bus handshake (valid/ready): data_req_o is the request valid and
//   data_addr_ok_i is its ready. A request is accepted on the cycle where
//   both are high. Once raised, the request is not withdrawn, and
//   addr/size/wstrb/wdata/wr hold steady until it is accepted.
//   data_data_ok_i is a single-cycle completion pulse. It arrives no earlier
//   than the cycle after acceptance.
//
// Ports
//   clk, rst (async, active-low)
//   mem_valid_i, mem_memop_i, mem_addr_i, mem_sdata_i, mem_rtold_i,
//   mem_except_i, mem_flush_i, pipe_stall_i   : pipeline side inputs
//   data_req_o, data_wr_o, data_size_o, data_addr_o, data_wstrb_o,
//   data_wdata_o, data_cached_o                : bus request
//   data_addr_ok_i, data_data_ok_i, data_rdata_i : bus responses
//   mem_rdata_o, mem_stall_o, mem_adel_o, mem_ades_o, mem_badvaddr_o
//   fsm_state_o                                : FSM state (debug)
module mem_access_unit #(
  parameter int ADDR_W   = 32,
  parameter bit KSEG1_UC = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid_i,
  input  logic [3:0]        mem_memop_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_sdata_i,
  input  logic [31:0]       mem_rtold_i,
  input  logic              mem_except_i,
  input  logic              mem_flush_i,
  input  logic              pipe_stall_i,
  output logic              data_req_o,
  output logic              data_wr_o,
  output logic [1:0]        data_size_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [3:0]        data_wstrb_o,
  output logic [31:0]       data_wdata_o,
  output logic              data_cached_o,
  input  logic              data_addr_ok_i,
  input  logic              data_data_ok_i,
  input  logic [31:0]       data_rdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_stall_o,
  output logic              mem_adel_o,
  output logic              mem_ades_o,
  output logic [31:0]       mem_badvaddr_o,
  output logic [1:0]        fsm_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state;
  logic        cancel;
  logic [3:0]  op_q;
  logic [1:0]  ofs_q;

  // Decode of the instruction currently in the EX/MEM latch
  logic        is_load;
  logic        is_store;
  logic        misaligned;
  logic [1:0]  size_d;
  logic [3:0]  strb_d;
  logic [31:0] wdata_d;
  logic [31:0] baddr_d;
  logic        live;
  logic        start;
  logic [31:0] load_val;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

`ifdef MEM_UNALIGNED_LWLR_EN
  logic [31:0] rtold_q;
`else
  logic        unused_rtold;
  assign unused_rtold = ^mem_rtold_i;
`endif

  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    size_d     = 2'd2;
    strb_d     = 4'b0000;
    wdata_d    = 32'h0;
    baddr_d    = mem_addr_i;
    case (mem_memop_i)
      4'h1, 4'h2: begin
        is_load = 1'b1;
        size_d  = 2'd0;
      end
      4'h3, 4'h4: begin
        is_load    = 1'b1;
        size_d     = 2'd1;
        misaligned = mem_addr_i[0];
      end
      4'h5: begin
        is_load    = 1'b1;
        misaligned = |mem_addr_i[1:0];
      end
      4'h6: begin
        is_store = 1'b1;
        size_d   = 2'd0;
        strb_d   = 4'b0001 << mem_addr_i[1:0];
        wdata_d  = {4{mem_sdata_i[7:0]}};
      end
      4'h7: begin
        is_store   = 1'b1;
        size_d     = 2'd1;
        misaligned = mem_addr_i[0];
        strb_d     = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d    = {2{mem_sdata_i[15:0]}};
      end
      4'h8: begin
        is_store   = 1'b1;
        misaligned = |mem_addr_i[1:0];
        strb_d     = 4'b1111;
        wdata_d    = mem_sdata_i;
      end
`ifdef MEM_UNALIGNED_LWLR_EN
      4'h9, 4'hA: begin
        is_load = 1'b1;
        baddr_d = {mem_addr_i[31:2], 2'b00};
      end
      // SWL stores the top (offset+1) bytes of rt into the low lanes.
      4'hB: begin
        is_store = 1'b1;
        baddr_d  = {mem_addr_i[31:2], 2'b00};
        case (mem_addr_i[1:0])
          2'd0:    begin strb_d = 4'b0001; wdata_d = {24'h0, mem_sdata_i[31:24]}; end
          2'd1:    begin strb_d = 4'b0011; wdata_d = {16'h0, mem_sdata_i[31:16]}; end
          2'd2:    begin strb_d = 4'b0111; wdata_d = {8'h0, mem_sdata_i[31:8]}; end
          default: begin strb_d = 4'b1111; wdata_d = mem_sdata_i; end
        endcase
      end
      // SWR stores the low (4-offset) bytes of rt into the high lanes.
      4'hC: begin
        is_store = 1'b1;
        baddr_d  = {mem_addr_i[31:2], 2'b00};
        case (mem_addr_i[1:0])
          2'd0:    begin strb_d = 4'b1111; wdata_d = mem_sdata_i; end
          2'd1:    begin strb_d = 4'b1110; wdata_d = {mem_sdata_i[23:0], 8'h0}; end
          2'd2:    begin strb_d = 4'b1100; wdata_d = {mem_sdata_i[15:0], 16'h0}; end
          default: begin strb_d = 4'b1000; wdata_d = {mem_sdata_i[7:0], 24'h0}; end
        endcase
      end
`endif
      default: ;
    endcase
  end

  // A new instruction can only be considered while idle. The pipeline holds
  // the latch contents stable during REQ/WAIT/DONE via the stall.
  assign live  = mem_valid_i & ~mem_except_i & ~mem_flush_i & (state == S_IDLE);
  assign start = live & (is_load | is_store) & ~misaligned;

  assign mem_adel_o     = live & is_load & misaligned;
  assign mem_ades_o     = live & is_store & misaligned;
  assign mem_badvaddr_o = (mem_adel_o | mem_ades_o) ? mem_addr_i : 32'h0;

  assign data_req_o  = (state == S_REQ);
  assign mem_stall_o = ((state == S_IDLE) & start) | (state == S_REQ) |
                       (state == S_WAIT) | ((state == S_DONE) & cancel);
  assign fsm_state_o = state;

  // Load extraction uses the offset and memop captured at launch.
  assign byte_sel = data_rdata_i[{ofs_q, 3'b000} +: 8];
  assign half_sel = data_rdata_i[{ofs_q[1], 4'b0000} +: 16];

  always_comb begin
    load_val = data_rdata_i;
    case (op_q)
      4'h1: load_val = {{24{byte_sel[7]}}, byte_sel};
      4'h2: load_val = {24'h0, byte_sel};
      4'h3: load_val = {{16{half_sel[15]}}, half_sel};
      4'h4: load_val = {16'h0, half_sel};
`ifdef MEM_UNALIGNED_LWLR_EN
      4'h9: begin
        case (ofs_q)
          2'd0:    load_val = {data_rdata_i[7:0], rtold_q[23:0]};
          2'd1:    load_val = {data_rdata_i[15:0], rtold_q[15:0]};
          2'd2:    load_val = {data_rdata_i[23:0], rtold_q[7:0]};
          default: load_val = data_rdata_i;
        endcase
      end
      4'hA: begin
        case (ofs_q)
          2'd0:    load_val = data_rdata_i;
          2'd1:    load_val = {rtold_q[31:24], data_rdata_i[31:8]};
          2'd2:    load_val = {rtold_q[31:16], data_rdata_i[31:16]};
          default: load_val = {rtold_q[31:8], data_rdata_i[31:24]};
        endcase
      end
`endif
      default: load_val = data_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      cancel        <= 1'b0;
      op_q          <= 4'h0;
      ofs_q         <= 2'd0;
      data_wr_o     <= 1'b0;
      data_size_o   <= 2'd0;
      data_addr_o   <= '0;
      data_wstrb_o  <= 4'b0000;
      data_wdata_o  <= 32'h0;
      data_cached_o <= 1'b0;
      mem_rdata_o   <= 32'h0;
`ifdef MEM_UNALIGNED_LWLR_EN
      rtold_q       <= 32'h0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_REQ;
            cancel        <= 1'b0;
            op_q          <= mem_memop_i;
            ofs_q         <= mem_addr_i[1:0];
            data_wr_o     <= is_store;
            data_size_o   <= size_d;
            data_addr_o   <= baddr_d[ADDR_W-1:0];
            data_wstrb_o  <= strb_d;
            data_wdata_o  <= wdata_d;
            data_cached_o <= ~(KSEG1_UC && (mem_addr_i[31:29] == 3'b101));
            // Cleared so a cancelled or store access leaves a zero result.
            mem_rdata_o   <= 32'h0;
`ifdef MEM_UNALIGNED_LWLR_EN
            rtold_q       <= mem_rtold_i;
`endif
          end
        end
        S_REQ: begin
          if (mem_flush_i) cancel <= 1'b1;
          if (data_addr_ok_i) state <= S_WAIT;
        end
        S_WAIT: begin
          if (data_data_ok_i) begin
            // A flushed access still finishes on the bus; its data is dropped.
            if (cancel || mem_flush_i) begin
              state  <= S_IDLE;
              cancel <= 1'b0;
            end else begin
              state <= S_DONE;
              if (!data_wr_o) mem_rdata_o <= load_val;
            end
          end else if (mem_flush_i) begin
            cancel <= 1'b1;
          end
        end
        S_DONE: begin
          if (mem_flush_i || !pipe_stall_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
